// File: rtl/biriscv_decode_fifo_if.sv
// Fetch-to-decode handshake bundle for biriscv_decode_fifo.
// master drives fetch/pop requests, slave is the FIFO itself.
interface biriscv_decode_fifo_if #(
    parameter int LEVEL_W = 3
);
    logic               flush_i;
    logic               enable_muldiv_i;
    logic               fetch_valid_i;
    logic [31:0]        fetch_instr_i;
    logic [31:0]        fetch_pc_i;
    logic               fetch_fault_i;
    logic               fetch_accept_o;
    logic               out_valid_o;
    logic [31:0]        out_instr_o;
    logic [31:0]        out_pc_o;
    logic               out_fault_o;
    logic               out_invalid_o;
    logic               out_exec_o;
    logic               out_lsu_o;
    logic               out_branch_o;
    logic               out_mul_o;
    logic               out_div_o;
    logic               out_csr_o;
    logic               out_rd_valid_o;
    logic               out_accept_i;
    logic [LEVEL_W-1:0] level_o;

    modport master (
        output flush_i, enable_muldiv_i, fetch_valid_i,
        output fetch_instr_i, fetch_pc_i, fetch_fault_i,
        output out_accept_i,
        input  fetch_accept_o, out_valid_o, out_instr_o, out_pc_o,
        input  out_fault_o, out_invalid_o, out_exec_o, out_lsu_o,
        input  out_branch_o, out_mul_o, out_div_o, out_csr_o,
        input  out_rd_valid_o, level_o
    );

    modport slave (
        input  flush_i, enable_muldiv_i, fetch_valid_i,
        input  fetch_instr_i, fetch_pc_i, fetch_fault_i,
        input  out_accept_i,
        output fetch_accept_o, out_valid_o, out_instr_o, out_pc_o,
        output out_fault_o, out_invalid_o, out_exec_o, out_lsu_o,
        output out_branch_o, out_mul_o, out_div_o, out_csr_o,
        output out_rd_valid_o, level_o
    );
endinterface

// File: rtl/biriscv_decode_fifo.sv
// Instruction FIFO that pre-decodes RV32IM class flags at push time.
// Optional BIRISCV_DECODE_FIFO_BYPASS_EN: empty-FIFO fetch-to-out bypass.
module biriscv_decode_fifo #(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    biriscv_decode_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic fault;
        logic invalid;
        logic exec;
        logic lsu;
        logic branch;
        logic mul;
        logic div;
        logic csr;
        logic rd_valid;
    } flags_t;

    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        pc_q    [DEPTH];
    flags_t             flags_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;

    logic   empty;
    logic   accept;
    logic   take;
    logic   push;
    logic   pop;
    flags_t dec;
    flags_t out_flags;

    // Decode via mask/match on the whole word.
    logic [31:0] w;
    logic d_exec, d_load, d_store, d_jal, d_jalr, d_bxx;
    logic d_mul, d_div, d_csrr, d_sys, d_known;

    assign w = bus.fetch_instr_i;

    assign d_exec =
        ((w & 32'h0000007f) inside {32'h37, 32'h17}) ||
        ((w & 32'h0000707f) inside {32'h13, 32'h2013, 32'h3013,
                                    32'h4013, 32'h6013, 32'h7013}) ||
        ((w & 32'hfe00707f) inside {32'h1013, 32'h5013, 32'h40005013,
                                    32'h40000033, 32'h40005033}) ||
        ((w & 32'hfe00007f) == 32'h33);
    assign d_load  = (w & 32'h707f) inside {32'h0003, 32'h1003, 32'h2003,
                                            32'h4003, 32'h5003, 32'h6003};
    assign d_store = (w & 32'h707f) inside {32'h0023, 32'h1023, 32'h2023};
    assign d_jal   = (w & 32'h7f) == 32'h6f;
    assign d_jalr  = (w & 32'h707f) == 32'h67;
    assign d_bxx   = (w & 32'h707f) inside {32'h0063, 32'h1063, 32'h4063,
                                            32'h5063, 32'h6063, 32'h7063};
    assign d_mul   = bus.enable_muldiv_i &&
                     ((w & 32'hfe00407f) == 32'h02000033);
    assign d_div   = bus.enable_muldiv_i &&
                     ((w & 32'hfe00407f) == 32'h02004033);
    assign d_csrr  = (w & 32'h707f) inside {32'h1073, 32'h2073, 32'h3073,
                                            32'h5073, 32'h6073, 32'h7073};
    assign d_sys   =
        (w inside {32'h00000073, 32'h00100073,
                   32'h30200073, 32'h10500073}) ||
        ((w & 32'h707f) inside {32'h000f, 32'h100f}) ||
        ((w & 32'hfe007fff) == 32'h12000073) ||
        d_csrr;
    assign d_known = d_exec | d_load | d_store | d_jal | d_jalr |
                     d_bxx | d_mul | d_div | d_sys;

    always_comb begin
        dec = '0;
        if (bus.fetch_fault_i) begin
            dec.fault = 1'b1;
            dec.csr   = 1'b1;
        end else begin
            dec.invalid  = !d_known;
            dec.exec     = d_exec;
            dec.lsu      = d_load | d_store;
            dec.branch   = d_jal | d_jalr | d_bxx;
            dec.mul      = d_mul;
            dec.div      = d_div;
            dec.csr      = d_sys | !d_known;
            dec.rd_valid = d_exec | d_load | d_jal | d_jalr |
                           d_mul | d_div | d_csrr;
        end
    end

    assign empty  = (level_q == '0);
    assign accept = (level_q < LEVEL_W'(DEPTH));

`ifdef BIRISCV_DECODE_FIFO_BYPASS_EN
    assign take = empty && bus.fetch_valid_i &&
                  bus.out_accept_i && !bus.flush_i;
`else
    assign take = 1'b0;
`endif

    assign push = bus.fetch_valid_i && accept && !bus.flush_i && !take;
    assign pop  = !empty && bus.out_accept_i && !bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (pop && !push)
                level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr_q] <= bus.fetch_instr_i;
            pc_q[wr_ptr_q]    <= bus.fetch_pc_i;
            flags_q[wr_ptr_q] <= dec;
        end
    end

    always_comb begin
        bus.out_valid_o = !empty;
        bus.out_instr_o = instr_q[rd_ptr_q];
        bus.out_pc_o    = pc_q[rd_ptr_q];
        out_flags       = empty ? '0 : flags_q[rd_ptr_q];
`ifdef BIRISCV_DECODE_FIFO_BYPASS_EN
        if (empty) begin
            bus.out_valid_o = bus.fetch_valid_i;
            bus.out_instr_o = bus.fetch_instr_i;
            bus.out_pc_o    = bus.fetch_pc_i;
            out_flags       = bus.fetch_valid_i ? dec : '0;
        end
`endif
    end

    assign bus.fetch_accept_o = accept;
    assign bus.level_o        = level_q;
    assign bus.out_fault_o    = out_flags.fault;
    assign bus.out_invalid_o  = out_flags.invalid;
    assign bus.out_exec_o     = out_flags.exec;
    assign bus.out_lsu_o      = out_flags.lsu;
    assign bus.out_branch_o   = out_flags.branch;
    assign bus.out_mul_o      = out_flags.mul;
    assign bus.out_div_o      = out_flags.div;
    assign bus.out_csr_o      = out_flags.csr;
    assign bus.out_rd_valid_o = out_flags.rd_valid;
endmodule
